// File: rtl/hpdmc_wrpath16_pkg.sv
// Shared state encoding and idle-bus constants for the 16-bit DDR write path.
package hpdmc_wrpath16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_POST = 3'd4
  } wr_state_e;

  // Between bursts the DQ bus carries zeros and every byte lane is masked.
  localparam logic [15:0] DQ_IDLE = 16'h0000;
  localparam logic [1:0]  DM_IDLE = 2'b11;

endpackage

// File: rtl/hpdmc_wrpath16.sv
// Write-data sequencer: turns a WRITE command plus bus words into per-cycle
// rise/fall DQ, DM and DQS half-words with enables for the ODDR bank.
//
// state | meaning
// IDLE  | no burst; a write pulse starts one
// WAIT  | counting out the remaining write latency
// PRE   | DQS preamble driven low, first word sampled
// DATA  | one 32-bit word per cycle on DQ, DQS toggling
// POST  | DQS postamble driven low, then back to IDLE
module hpdmc_wrpath16
  import hpdmc_wrpath16_pkg::*;
#(
  parameter int BURST_WORDS = 4,
  parameter int WRITE_DELAY = 1
) (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] dq_rise,
  output logic [15:0] dq_fall,
  output logic [1:0]  dm_rise,
  output logic [1:0]  dm_fall,
  output logic        dq_oe,
  output logic        dqs_rise,
  output logic        dqs_fall,
  output logic        dqs_oe,
  output logic        busy,
  output logic        underrun,
  output logic        write_err
);

  localparam int DLY_W  = (WRITE_DELAY > 2) ? $clog2(WRITE_DELAY - 1) : 1;
  localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'((WRITE_DELAY > 1) ? WRITE_DELAY - 2 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BURST_WORDS - 1);

  wr_state_e         state, state_nx;
  logic [DLY_W-1:0]  dly_cnt, dly_nx;
  logic [BEAT_W-1:0] beat_cnt, beat_nx;
  logic              take_word;

  always_comb begin
    state_nx = state;
    dly_nx   = dly_cnt;
    beat_nx  = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (write) begin
          if (WRITE_DELAY == 1) begin
            state_nx = ST_PRE;
          end else begin
            state_nx = ST_WAIT;
            dly_nx   = DLY_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (dly_cnt == '0) state_nx = ST_PRE;
        else               dly_nx   = dly_cnt - DLY_W'(1);
      end
      ST_PRE: begin
        state_nx = ST_DATA;
        beat_nx  = BEAT_LOAD;
      end
      ST_DATA: begin
        if (beat_cnt == '0) state_nx = ST_POST;
        else                beat_nx  = beat_cnt - BEAT_W'(1);
      end
      ST_POST: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A word sampled now is the one shown during the next DATA cycle.
  always_comb begin
    take_word   = (state == ST_PRE) || ((state == ST_DATA) && (beat_cnt != '0));
    wdata_ready = take_word;
  end

  assign dqs_fall = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state     <= ST_IDLE;
      dly_cnt   <= '0;
      beat_cnt  <= '0;
      dq_rise   <= DQ_IDLE;
      dq_fall   <= DQ_IDLE;
      dm_rise   <= DM_IDLE;
      dm_fall   <= DM_IDLE;
      dq_oe     <= 1'b0;
      dqs_rise  <= 1'b0;
      dqs_oe    <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      write_err <= 1'b0;
    end else begin
      state     <= state_nx;
      dly_cnt   <= dly_nx;
      beat_cnt  <= beat_nx;
      dq_oe     <= (state_nx == ST_DATA);
      dqs_rise  <= (state_nx == ST_DATA);
      dqs_oe    <= (state_nx == ST_PRE) || (state_nx == ST_DATA) || (state_nx == ST_POST);
      busy      <= (state_nx != ST_IDLE);
      write_err <= write && (state != ST_IDLE);
      underrun  <= take_word && !wdata_valid;
      if (take_word && wdata_valid) begin
        dq_rise <= wdata[31:16];
        dq_fall <= wdata[15:0];
        dm_rise <= ~wmask[3:2];
        dm_fall <= ~wmask[1:0];
      end else begin
        dq_rise <= DQ_IDLE;
        dq_fall <= DQ_IDLE;
        dm_rise <= DM_IDLE;
        dm_fall <= DM_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hpdmc_wrpath16.sv
// Bench for hpdmc_wrpath16: two instances (write latency 1 and 3) share one
// stimulus stream; a cycle-schedule model feeds per-DUT scoreboards.
module tb_hpdmc_wrpath16;
  import hpdmc_wrpath16_pkg::*;

  localparam int BW  = 4;
  localparam int WD0 = 1;
  localparam int WD1 = 3;
  localparam int P_IDLE = 0, P_WAIT = 1, P_PRE = 2, P_DATA = 3, P_POST = 4;

  typedef struct packed {
    int   cyc;
    logic dqs_oe, dq_oe, dqs_rise, busy, ready, werr, under;
  } ctrl_t;

  typedef struct packed {
    logic [15:0] r, f;
    logic [1:0]  mr, mf;
  } beat_t;

  logic        sys_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wdata_valid = 1'b0;

  logic        wdata_ready [2];
  logic [15:0] dq_rise [2];
  logic [15:0] dq_fall [2];
  logic [1:0]  dm_rise [2];
  logic [1:0]  dm_fall [2];
  logic        dq_oe [2];
  logic        dqs_rise [2];
  logic        dqs_fall [2];
  logic        dqs_oe [2];
  logic        busy [2];
  logic        underrun [2];
  logic        write_err [2];

  hpdmc_wrpath16 #(.BURST_WORDS(BW), .WRITE_DELAY(WD0)) u_dut0 (
    .sys_clk(sys_clk), .sdram_rst(sdram_rst), .write(write), .wdata(wdata),
    .wmask(wmask), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready[0]),
    .dq_rise(dq_rise[0]), .dq_fall(dq_fall[0]), .dm_rise(dm_rise[0]), .dm_fall(dm_fall[0]),
    .dq_oe(dq_oe[0]), .dqs_rise(dqs_rise[0]), .dqs_fall(dqs_fall[0]), .dqs_oe(dqs_oe[0]),
    .busy(busy[0]), .underrun(underrun[0]), .write_err(write_err[0])
  );

  hpdmc_wrpath16 #(.BURST_WORDS(BW), .WRITE_DELAY(WD1)) u_dut1 (
    .sys_clk(sys_clk), .sdram_rst(sdram_rst), .write(write), .wdata(wdata),
    .wmask(wmask), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready[1]),
    .dq_rise(dq_rise[1]), .dq_fall(dq_fall[1]), .dm_rise(dm_rise[1]), .dm_fall(dm_fall[1]),
    .dq_oe(dq_oe[1]), .dqs_rise(dqs_rise[1]), .dqs_fall(dqs_fall[1]), .dqs_oe(dqs_oe[1]),
    .busy(busy[1]), .underrun(underrun[1]), .write_err(write_err[1])
  );

  always #5 sys_clk = ~sys_clk;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  bit    run = 1'b1;
  int    acc [2];
  int    pre [2];
  ctrl_t qc [2][$];
  beat_t qb [2][$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
    end
  endtask

  // Phase of DUT d in cycle m, from the accepted-write cycle and preamble cycle.
  function automatic int ph(input int d, input int m);
    if (m > acc[d] && m < pre[d]) return P_WAIT;
    if (m == pre[d]) return P_PRE;
    if (m > pre[d] && m <= pre[d] + BW) return P_DATA;
    if (m == pre[d] + BW + 1) return P_POST;
    return P_IDLE;
  endfunction

  task automatic step(input logic w, input logic v, input logic r,
                      input logic [31:0] dat, input logic [3:0] msk);
    @(posedge sys_clk);
    #1;
    write = w; wdata_valid = v; sdram_rst = r; wdata = dat; wmask = msk;
    for (int d = 0; d < 2; d++) begin
      int    pn, p1;
      logic  samp;
      ctrl_t c;
      beat_t b;
      pn = ph(d, cyc);
      samp = 1'b0;
      c = '0;
      c.cyc = cyc + 1;
      if (r) begin
        acc[d] = -1000;
        pre[d] = -1000;
      end else begin
        if (w && pn != P_IDLE) c.werr = 1'b1;
        if (w && pn == P_IDLE) begin
          acc[d] = cyc;
          pre[d] = cyc + ((d == 0) ? WD0 : WD1);
        end
        samp = (cyc >= pre[d]) && (cyc <= pre[d] + BW - 1);
        if (samp) begin
          if (v) begin
            b.r = dat[31:16]; b.f = dat[15:0]; b.mr = ~msk[3:2]; b.mf = ~msk[1:0];
          end else begin
            b.r = 16'h0; b.f = 16'h0; b.mr = 2'b11; b.mf = 2'b11;
          end
          qb[d].push_back(b);
        end
        c.under = samp && !v;
      end
      p1 = ph(d, cyc + 1);
      c.dqs_oe   = (p1 == P_PRE) || (p1 == P_DATA) || (p1 == P_POST);
      c.dq_oe    = (p1 == P_DATA);
      c.dqs_rise = (p1 == P_DATA);
      c.busy     = (p1 != P_IDLE);
      c.ready    = (p1 == P_PRE) || (p1 == P_DATA && cyc + 1 <= pre[d] + BW - 1);
      qc[d].push_back(c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, $urandom, 4'($urandom_range(0, 15)));
  endtask

  always @(negedge sys_clk) begin
    ctrl_t c;
    beat_t b;
    if (run && cyc >= 2) begin
      for (int d = 0; d < 2; d++) begin
        while (qc[d].size() > 0 && qc[d][0].cyc < cyc) begin
          c = qc[d].pop_front();
          chk("ctrl_stale", d, 32'(c.cyc), 32'(cyc));
        end
        if (qc[d].size() == 0 || qc[d][0].cyc != cyc) begin
          chk("ctrl_missing", d, 32'(qc[d].size()), 32'(qc[d].size() + 1));
        end else begin
          c = qc[d].pop_front();
          chk("dqs_oe", d, 32'(dqs_oe[d]), 32'(c.dqs_oe));
          chk("dq_oe", d, 32'(dq_oe[d]), 32'(c.dq_oe));
          chk("dqs_rise", d, 32'(dqs_rise[d]), 32'(c.dqs_rise));
          chk("dqs_fall", d, 32'(dqs_fall[d]), 32'h0);
          chk("busy", d, 32'(busy[d]), 32'(c.busy));
          chk("wdata_ready", d, 32'(wdata_ready[d]), 32'(c.ready));
          chk("write_err", d, 32'(write_err[d]), 32'(c.werr));
          chk("underrun", d, 32'(underrun[d]), 32'(c.under));
        end
        if (dq_oe[d] === 1'b1) begin
          if (qb[d].size() == 0) begin
            chk("beat_unexpected", d, 32'h1, 32'h0);
          end else begin
            b = qb[d].pop_front();
            chk("dq_rise", d, 32'(dq_rise[d]), 32'(b.r));
            chk("dq_fall", d, 32'(dq_fall[d]), 32'(b.f));
            chk("dm_rise", d, 32'(dm_rise[d]), 32'(b.mr));
            chk("dm_fall", d, 32'(dm_fall[d]), 32'(b.mf));
          end
        end else begin
          chk("dq_rise_idle", d, 32'(dq_rise[d]), 32'(DQ_IDLE));
          chk("dq_fall_idle", d, 32'(dq_fall[d]), 32'(DQ_IDLE));
          chk("dm_rise_idle", d, 32'(dm_rise[d]), 32'(DM_IDLE));
          chk("dm_fall_idle", d, 32'(dm_fall[d]), 32'(DM_IDLE));
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      acc[d] = -1000;
      pre[d] = -1000;
    end
    step(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    idle(2);

    // Basic burst with the reference words, full byte enables
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hAAAA5555, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'h12345678, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hFFFF0000, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'h0F0FF0F0, 4'hF);
    idle(8);

    // Partial masks
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'h11112222, 4'h3);
    step(1'b0, 1'b1, 1'b0, 32'h33334444, 4'hC);
    step(1'b0, 1'b1, 1'b0, 32'h55556666, 4'h3);
    step(1'b0, 1'b1, 1'b0, 32'h77778888, 4'hC);
    idle(8);

    // Underrun on the second sample
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hCAFE0001, 4'hF);
    step(1'b0, 1'b0, 1'b0, 32'hCAFE0002, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hCAFE0003, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hCAFE0004, 4'hF);
    idle(8);

    // Write while busy is rejected
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hBEEF0001, 4'hF);
    step(1'b1, 1'b1, 1'b0, 32'hBEEF0002, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hBEEF0003, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hBEEF0004, 4'hF);
    idle(10);

    // Reset in the second DATA cycle, then a clean burst
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hD00D0001, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hD00D0002, 4'hF);
    step(1'b1, 1'b1, 1'b1, 32'hD00D0003, 4'hF);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hE0E00001, 4'hA);
    step(1'b0, 1'b1, 1'b0, 32'hE0E00002, 4'h5);
    step(1'b0, 1'b1, 1'b0, 32'hE0E00003, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'hE0E00004, 4'h0);
    idle(10);

    // Randomized traffic: writes, gaps in valid data, occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 79) == 0), $urandom, 4'($urandom_range(0, 15)));
    end
    idle(12);

    repeat (2) @(posedge sys_clk);
    run = 1'b0;
    for (int d = 0; d < 2; d++) chk("beats_left", d, 32'(qb[d].size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
